// File: rtl/mrmw_mem_lanes.sv
// Parametrised multi-read/multi-write memory with per-lane write masks, lane valid tracking,
// highest-writer-wins collision resolution and selectable combinational or registered-address read.
module mrmw_mem_lanes #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LANE_BITS = 8,
  parameter int unsigned READERS   = 2,
  parameter int unsigned WRITERS   = 2,
  parameter int unsigned SYNC_READ = 0
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [READERS-1:0]                     read_ens,
  input  logic [ADDR_BITS*READERS-1:0]           read_addrs,
  output logic [WIDTH*READERS-1:0]               read_datas,
  input  logic [WRITERS-1:0]                     write_ens,
  input  logic [(WIDTH/LANE_BITS)*WRITERS-1:0]   write_masks,
  input  logic [ADDR_BITS*WRITERS-1:0]           write_addrs,
  input  logic [WIDTH*WRITERS-1:0]               write_datas,
  output logic                                   collision,
  output logic [15:0]                            collision_count
);

  localparam int unsigned LANES = WIDTH / LANE_BITS;

  logic [WIDTH-1:0]     r_mem      [DEPTH];
  logic [LANES-1:0]     r_valid    [DEPTH];
  logic [ADDR_BITS-1:0] r_raddr    [READERS];
  logic                 r_coll;
  logic [15:0]          r_coll_cnt;

  logic [LANES-1:0]     w_we       [DEPTH];
  logic [WIDTH-1:0]     w_wd       [DEPTH];
  logic                 w_coll;
  logic [ADDR_BITS-1:0] w_rsel     [READERS];
  logic [WIDTH-1:0]     w_rd       [READERS];

  // Writers are scanned in ascending order so the highest index overwrites per lane. Only
  // addresses 0..DEPTH-1 are ever matched, so out-of-range writes never land or collide.
  always_comb begin
    w_coll = 1'b0;
    for (int d = 0; d < DEPTH; d++) begin
      w_we[d] = '0;
      w_wd[d] = '0;
      for (int w = 0; w < WRITERS; w++) begin
        if (write_ens[w] && (write_addrs[w*ADDR_BITS +: ADDR_BITS] == ADDR_BITS'(d))) begin
          for (int l = 0; l < LANES; l++) begin
            if (write_masks[w*LANES + l]) begin
              if (w_we[d][l]) w_coll = 1'b1;
              w_we[d][l] = 1'b1;
              w_wd[d][l*LANE_BITS +: LANE_BITS] = write_datas[w*WIDTH + l*LANE_BITS +: LANE_BITS];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int d = 0; d < DEPTH; d++) begin
        for (int l = 0; l < LANES; l++) begin
          if (w_we[d][l]) r_mem[d][l*LANE_BITS +: LANE_BITS] <= w_wd[d][l*LANE_BITS +: LANE_BITS];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < DEPTH; d++) r_valid[d] <= '0;
      r_coll     <= 1'b0;
      r_coll_cnt <= '0;
    end else begin
      for (int d = 0; d < DEPTH; d++) r_valid[d] <= r_valid[d] | w_we[d];
      r_coll <= w_coll;
      if (w_coll && (r_coll_cnt != 16'hFFFF)) r_coll_cnt <= r_coll_cnt + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < READERS; r++) r_raddr[r] <= '0;
    end else begin
      for (int r = 0; r < READERS; r++) begin
        if (read_ens[r]) r_raddr[r] <= read_addrs[r*ADDR_BITS +: ADDR_BITS];
      end
    end
  end

  // Lookup is a decode over valid entries, so an out-of-range address simply matches nothing.
  always_comb begin
    read_datas = '0;
    for (int r = 0; r < READERS; r++) begin
      w_rsel[r] = (SYNC_READ != 0) ? r_raddr[r] : read_addrs[r*ADDR_BITS +: ADDR_BITS];
      w_rd[r]   = '0;
      for (int d = 0; d < DEPTH; d++) begin
        if (w_rsel[r] == ADDR_BITS'(d)) begin
          for (int l = 0; l < LANES; l++) begin
            if (r_valid[d][l]) w_rd[r][l*LANE_BITS +: LANE_BITS] = r_mem[d][l*LANE_BITS +: LANE_BITS];
          end
        end
      end
      read_datas[r*WIDTH +: WIDTH] = w_rd[r];
    end
  end

  assign collision       = r_coll;
  assign collision_count = r_coll_cnt;

endmodule

// File: tb/tb_mrmw_mem_lanes.sv
// Scoreboard bench: an async-read default instance and a sync-read DEPTH=12 instance share
// clock and reset; stimulus queues expectations tagged with the cycle they are due.
module tb_mrmw_mem_lanes;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Async-read instance (defaults)
  logic [1:0]  a_ren = '0;
  logic [7:0]  a_raddr = '0;
  logic [63:0] a_rdata;
  logic [1:0]  a_wen = '0;
  logic [7:0]  a_wmask = '0;
  logic [7:0]  a_waddr = '0;
  logic [63:0] a_wdata = '0;
  logic        a_coll;
  logic [15:0] a_cnt;

  // Sync-read instance, DEPTH=12
  logic [1:0]  s_ren = '0;
  logic [7:0]  s_raddr = '0;
  logic [63:0] s_rdata;
  logic [1:0]  s_wen = '0;
  logic [7:0]  s_wmask = '0;
  logic [7:0]  s_waddr = '0;
  logic [63:0] s_wdata = '0;
  logic        s_coll;
  logic [15:0] s_cnt;

  mrmw_mem_lanes u_async (
    .clock          (clk),
    .reset          (rst),
    .read_ens       (a_ren),
    .read_addrs     (a_raddr),
    .read_datas     (a_rdata),
    .write_ens      (a_wen),
    .write_masks    (a_wmask),
    .write_addrs    (a_waddr),
    .write_datas    (a_wdata),
    .collision      (a_coll),
    .collision_count(a_cnt)
  );

  mrmw_mem_lanes #(
    .DEPTH    (12),
    .SYNC_READ(1)
  ) u_sync (
    .clock          (clk),
    .reset          (rst),
    .read_ens       (s_ren),
    .read_addrs     (s_raddr),
    .read_datas     (s_rdata),
    .write_ens      (s_wen),
    .write_masks    (s_wmask),
    .write_addrs    (s_waddr),
    .write_datas    (s_wdata),
    .collision      (s_coll),
    .collision_count(s_cnt)
  );

  localparam int ARD0 = 0, ARD1 = 1, ACOLL = 2, ACNT = 3;
  localparam int SRD0 = 4, SRD1 = 5, SCOLL = 6, SCNT = 7;

  typedef struct {
    int          due;
    int          id;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [63:0] actual(input int id);
    case (id)
      ARD0:    return {32'd0, a_rdata[31:0]};
      ARD1:    return {32'd0, a_rdata[63:32]};
      ACOLL:   return {63'd0, a_coll};
      ACNT:    return {48'd0, a_cnt};
      SRD0:    return {32'd0, s_rdata[31:0]};
      SRD1:    return {32'd0, s_rdata[63:32]};
      SCOLL:   return {63'd0, s_coll};
      default: return {48'd0, s_cnt};
    endcase
  endfunction

  task automatic expect_at(input int id, input logic [63:0] v, input int dly, input string nm);
    sb.push_back('{cyc + dly, id, v, nm});
  endtask

  // Monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    exp_t keep[$];
    logic [63:0] got;
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].due == cyc) begin
        got = actual(sb[i].id);
        n_tests++;
        if (got !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %h, expected %h", sb[i].name, cyc, got, sb[i].val);
        end
      end else if (sb[i].due < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: never sampled (due cyc %0d)", sb[i].name, sb[i].due);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_wen = '0; a_wmask = '0; a_ren = '0;
    s_wen = '0; s_wmask = '0; s_ren = '0;
  endtask

  task automatic a_write(input int w, input logic [3:0] addr, input logic [3:0] m,
                         input logic [31:0] d);
    a_wen[w] = 1'b1;
    a_waddr[w*4 +: 4] = addr;
    a_wmask[w*4 +: 4] = m;
    a_wdata[w*32 +: 32] = d;
  endtask

  task automatic s_write(input int w, input logic [3:0] addr, input logic [3:0] m,
                         input logic [31:0] d);
    s_wen[w] = 1'b1;
    s_waddr[w*4 +: 4] = addr;
    s_wmask[w*4 +: 4] = m;
    s_wdata[w*32 +: 32] = d;
  endtask

  initial begin
    a_raddr = {4'd3, 4'd3};

    step();  // in reset
    expect_at(ARD0, 64'h0, 0, "reset_a_rd0");
    expect_at(ARD1, 64'h0, 0, "reset_a_rd1");
    expect_at(ACOLL, 64'h0, 0, "reset_a_coll");
    expect_at(ACNT, 64'h0, 0, "reset_a_cnt");
    expect_at(SRD0, 64'h0, 0, "reset_s_rd0");
    expect_at(SCNT, 64'h0, 0, "reset_s_cnt");
    rst = 1'b0;

    step();
    a_write(0, 4'd3, 4'hF, 32'hDEADBEEF);
    expect_at(ARD0, 64'h0, 0, "a_read_before_write");
    expect_at(ARD0, 64'hDEADBEEF, 1, "a_full_write");
    s_ren[0] = 1'b1; s_raddr[3:0] = 4'd7;
    s_write(0, 4'd7, 4'hF, 32'h55);
    expect_at(SRD0, 64'h0, 0, "s_before_capture");
    expect_at(SRD0, 64'h55, 1, "s_write_first");

    step(); idle();
    a_write(0, 4'd4, 4'b0101, 32'h11223344);
    a_raddr[7:4] = 4'd4;
    s_raddr[3:0] = 4'd2;  // enable low: register must hold 7
    s_write(0, 4'd7, 4'hF, 32'h66);
    expect_at(SRD0, 64'h55, 0, "s_hold_old");
    expect_at(SRD0, 64'h66, 1, "s_hold_tracks_write");

    step(); idle();
    a_write(0, 4'd4, 4'b1010, 32'hAABBCCDD);
    expect_at(ARD1, 64'h00220044, 0, "a_mask_0101");
    s_write(0, 4'd13, 4'hF, 32'h99);
    s_write(1, 4'd13, 4'hF, 32'h77);
    s_ren[1] = 1'b1; s_raddr[7:4] = 4'd13;
    expect_at(SCOLL, 64'h0, 1, "s_oor_no_coll");
    expect_at(SCNT, 64'h0, 1, "s_oor_no_count");
    expect_at(SRD1, 64'h0, 1, "s_oor_read_zero");
    expect_at(SRD0, 64'h66, 1, "s_oor_no_state_change");

    step(); idle();
    expect_at(ARD1, 64'hAA22CC44, 0, "a_mask_1010");
    a_write(0, 4'd5, 4'hF, 32'h1);
    a_write(1, 4'd5, 4'hF, 32'h2);
    a_raddr[3:0] = 4'd5;
    expect_at(ARD0, 64'h0, 0, "a_unwritten_zero");
    expect_at(ARD0, 64'h2, 1, "a_coll_high_wins");
    expect_at(ACOLL, 64'h1, 1, "a_coll_flag");
    expect_at(ACNT, 64'h1, 1, "a_coll_cnt1");
    s_write(0, 4'd11, 4'hF, 32'hA);
    s_write(1, 4'd11, 4'hF, 32'hB);
    s_ren[1] = 1'b1; s_raddr[7:4] = 4'd11;
    expect_at(SRD1, 64'hB, 1, "s_last_entry_high_wins");
    expect_at(SCOLL, 64'h1, 1, "s_coll_flag");
    expect_at(SCNT, 64'h1, 1, "s_coll_cnt1");

    step(); idle();
    a_write(0, 4'd5, 4'b0011, 32'h11111111);
    a_write(1, 4'd5, 4'b1100, 32'h22222222);
    expect_at(ACOLL, 64'h0, 1, "a_merge_no_coll");
    expect_at(ARD0, 64'h22221111, 1, "a_merge_data");
    expect_at(ACNT, 64'h1, 1, "a_merge_cnt");
    s_ren[1] = 1'b1; s_raddr[7:4] = 4'd1;
    expect_at(SRD1, 64'h0, 1, "s_no_alias_addr1");
    expect_at(SCOLL, 64'h0, 1, "s_coll_one_cycle");

    step(); idle();
    a_write(0, 4'd5, 4'b0011, 32'hAAAAAAAA);
    a_write(1, 4'd5, 4'b0110, 32'hBBBBBBBB);
    expect_at(ARD0, 64'h22BBBBAA, 1, "a_partial_coll_data");
    expect_at(ACOLL, 64'h1, 1, "a_partial_coll_flag");
    expect_at(ACNT, 64'h2, 1, "a_partial_coll_cnt");

    step(); idle();
    a_raddr[7:4] = 4'd3;
    expect_at(ARD1, 64'hDEADBEEF, 0, "a_addr3_retained");

    step(); idle();
    rst = 1'b1;
    a_write(0, 4'd6, 4'hF, 32'h12345678);
    s_write(0, 4'd0, 4'hF, 32'h12345678);
    expect_at(ARD0, 64'h0, 0, "rst_a_rd0");
    expect_at(ARD1, 64'h0, 0, "rst_a_rd1");
    expect_at(ACOLL, 64'h0, 0, "rst_a_coll");
    expect_at(ACNT, 64'h0, 0, "rst_a_cnt");
    expect_at(SRD0, 64'h0, 0, "rst_s_rd0");
    expect_at(SRD1, 64'h0, 0, "rst_s_rd1");
    expect_at(SCNT, 64'h0, 0, "rst_s_cnt");

    step();
    expect_at(ACNT, 64'h0, 0, "rst_a_cnt_held");
    expect_at(ARD0, 64'h0, 0, "rst_a_rd0_held");

    step(); idle();
    rst = 1'b0;
    a_write(0, 4'd5, 4'hF, 32'hCAFEF00D);
    a_raddr = {4'd6, 4'd5};
    expect_at(ARD0, 64'h0, 0, "post_rst_pre_edge");
    expect_at(ARD0, 64'hCAFEF00D, 1, "post_rst_first_write");
    expect_at(ARD1, 64'h0, 1, "rst_write_inhibited");
    expect_at(ACNT, 64'h0, 1, "post_rst_cnt");
    s_ren[0] = 1'b1; s_raddr[3:0] = 4'd0;
    s_write(0, 4'd0, 4'hF, 32'h0BADC0DE);
    expect_at(SRD0, 64'h0, 0, "s_rst_write_inhibited");
    expect_at(SRD0, 64'h0BADC0DE, 1, "s_post_rst_write");

    step(); idle();
    for (int i = 0; i < 5 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      foreach (sb[i]) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: still pending at end", sb[i].name);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mrmw_mem_lanes.md
Name: mrmw_mem_lanes

Overview:
Parametrised multi-read/multi-write memory. It is the next-generation replacement for the fixed 2R2W memory primitive that the FIRRTL memory lowering instantiates. Over that primitive it adds:
- per-lane write masks,
- deterministic write-collision resolution with collision reporting,
- per-lane valid tracking cleared by reset,
- a selectable sync or async read mode.

It sits behind the per-port CAT/BITS packing logic and keeps the same flat, port-packed bus convention: port n occupies slice [n*W +: W].

Parameters:
- DEPTH, 16, number of entries.
- ADDR_BITS, 4, address width; 2^ADDR_BITS >= DEPTH.
- WIDTH, 32, data bits per entry.
- LANE_BITS, 8, bits per mask lane; WIDTH % LANE_BITS == 0; LANES = WIDTH/LANE_BITS.
- READERS, 2, number of read ports, 1..8.
- WRITERS, 2, number of write ports, 1..8.
- SYNC_READ, 0, 0 = combinational read; 1 = registered address, 1-cycle latency.

Ports:
- clock, in, 1, single clock for all ports.
- reset, in, 1, asynchronous active-high reset.
- read_ens, in, READERS, per-reader enable; used only when SYNC_READ=1.
- read_addrs, in, ADDR_BITS*READERS, packed read addresses.
- read_datas, out, WIDTH*READERS, packed read data.
- write_ens, in, WRITERS, per-writer enable.
- write_masks, in, LANES*WRITERS, per-writer lane masks.
- write_addrs, in, ADDR_BITS*WRITERS, packed write addresses.
- write_datas, in, WIDTH*WRITERS, packed write data.
- collision, out, 1, registered: a lane collision occurred at the last edge.
- collision_count, out, 16, saturating count of collision edges.

Behaviour:

Storage:
- memcore is DEPTH x WIDTH and is not reset.
- lane_valid is DEPTH x LANES flops, asynchronously cleared by reset.
- A read lane returns 0 when its lane_valid bit is 0, otherwise the stored lane.

Write, per posedge clock:
- Writer w updates lane l of entry write_addrs[w] iff write_ens[w] & write_masks[w*LANES+l] & addr < DEPTH.
- Each written lane sets lane_valid. Unmasked lanes keep their data and valid bit.

Collision:
- Two or more writers targeting the same in-range address, with the same lane enabled, at the same edge.
- The highest-indexed writer wins, per lane. Distinct lanes of one address from different writers all land.
- collision is registered high for exactly the cycle after a colliding edge, and 0 otherwise.
- collision_count increments by 1 per colliding edge, regardless of how many lanes collided, and saturates at 16'hFFFF.

Out-of-range addresses (addr >= DEPTH):
- Writes are ignored and are not counted as collisions.
- Reads return 0.

Read, SYNC_READ=0:
- read_datas[r] = lane-masked memcore[read_addrs[r]], combinational.
- Read-before-write: a same-edge write becomes visible only after the edge.
- read_ens is ignored.

Read, SYNC_READ=1:
- The per-reader address register loads read_addrs[r] at posedge when read_ens[r]=1, and holds otherwise.
- Data is a combinational lookup at the registered address. It therefore reflects writes from the same capturing edge (write-first, 1-cycle latency).
- With the enable held low, the output tracks later writes to the held address.

Reset (asserted any time, including mid-burst):
- Asynchronously clears lane_valid, the address registers (to 0), collision and collision_count.
- All read_datas therefore go to 0 immediately.
- Writes are inhibited while reset is high.
- The first edge after deassertion behaves normally.

Width rules:
- No width truncation on data.
- Address compare uses the full ADDR_BITS.

Test Plan:
- Reset, then read addr 3 on all readers -> read_datas all 0. Write 0xDEADBEEF to addr 3, mask 4'hF -> next cycle reader 0 = 0xDEADBEEF (async mode).
- Mask 4'b0101 write of 0x11223344 to a fresh entry -> read 0x00220044. Then mask 4'b1010 write of 0xAABBCCDD -> read 0xAA22CC44.
- Writers 0 and 1 both hit addr 5, mask F, data 0x1 vs 0x2 -> mem = 0x2, collision=1 for one cycle, collision_count=1. Same addr with masks 0x3/0xC -> lanes merged, collision stays 0.
- SYNC_READ=1: read_en with addr 7 while writing 0x55 to addr 7 at the same edge -> 0x55 one cycle later. Drop read_en, write 0x66 to addr 7 -> output 0x66.
- DEPTH=12, ADDR_BITS=4: write to addr 13 -> no state change and no collision; read addr 13 -> 0.
- Reset pulse mid-stream after the entries above are filled -> all reads 0 and collision_count 0 while reset is high. After release, the first write lands correctly.
